// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin MESI snoop bus; sdt/sdr = cache requests/responses, sur/sut = peer snoops/replies, mem_req/mem_rsp = memory port
module snoop_bus_ctrl #(
  parameter int NUM_CACHE   = 4,
  parameter int SADDR_WIDTH = 58,
  parameter int BLK_WIDTH   = 512
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CACHE-1:0]             sdt_valid,
  output logic [NUM_CACHE-1:0]             sdt_ready,
  input  logic [3*NUM_CACHE-1:0]           sdt_op,
  input  logic [SADDR_WIDTH*NUM_CACHE-1:0] sdt_addr,
  input  logic [BLK_WIDTH*NUM_CACHE-1:0]   sdt_data,
  output logic [NUM_CACHE-1:0]             sdr_valid,
  input  logic [NUM_CACHE-1:0]             sdr_ready,
  output logic [2:0]                       sdr_rsp,
  output logic [BLK_WIDTH-1:0]             sdr_data,
  output logic [NUM_CACHE-1:0]             sur_valid,
  input  logic [NUM_CACHE-1:0]             sur_ready,
  output logic [1:0]                       sur_op,
  output logic [SADDR_WIDTH-1:0]           sur_addr,
  input  logic [NUM_CACHE-1:0]             sut_valid,
  output logic [NUM_CACHE-1:0]             sut_ready,
  input  logic [2*NUM_CACHE-1:0]           sut_rsp,
  input  logic [BLK_WIDTH*NUM_CACHE-1:0]   sut_data,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_we,
  output logic [SADDR_WIDTH-1:0]           mem_req_addr,
  output logic [BLK_WIDTH-1:0]             mem_req_data,
  input  logic                             mem_rsp_valid,
  input  logic [BLK_WIDTH-1:0]             mem_rsp_data
);
  localparam int PW = NUM_CACHE > 1 ? $clog2(NUM_CACHE) : 1;
  localparam logic [2:0] OP_RD = 3'd1, OP_RDX = 3'd2, OP_UPGR = 3'd3, OP_WB = 3'd4;
  localparam logic [2:0] R_SNOOP = 3'd1, R_FETCH = 3'd2, R_FETCH_EXCL = 3'd3, R_ACK = 3'd4;
  typedef enum logic [2:0] {IDLE, SNP_ISSUE, SNP_COLLECT, MEM_REQ, MEM_WAIT, RESP} state_t;
  typedef struct packed {state_t st; logic we; logic [2:0] rsp;} dec_t;
  state_t state, state_n;
  logic [2:0] op_a [NUM_CACHE];
  logic [SADDR_WIDTH-1:0] addr_a [NUM_CACHE];
  logic [BLK_WIDTH-1:0] wdata_a [NUM_CACHE];
  logic [1:0] rsp_a [NUM_CACHE];
  logic [BLK_WIDTH-1:0] sdata_a [NUM_CACHE];
  logic [PW-1:0] ptr, req_idx, grant, cand, dirty_idx, didx_c;
  logic [NUM_CACHE-1:0] gsel, pend_sur, pend_sut;
  logic found, any_hit, dirty_found, hit_c, dirty_c, take, all_sur, all_sut, is_snp;
  logic [2:0] op_q, rsp_q, g_op;
  logic [SADDR_WIDTH-1:0] addr_q;
  logic [BLK_WIDTH-1:0] data_q;
  dec_t dec, d0;
  for (genvar g = 0; g < NUM_CACHE; g++) begin : g_unpack
    assign op_a[g]    = sdt_op[3*g +: 3];
    assign addr_a[g]  = sdt_addr[SADDR_WIDTH*g +: SADDR_WIDTH];
    assign wdata_a[g] = sdt_data[BLK_WIDTH*g +: BLK_WIDTH];
    assign rsp_a[g]   = sut_rsp[2*g +: 2];
    assign sdata_a[g] = sut_data[BLK_WIDTH*g +: BLK_WIDTH];
  end
  function automatic dec_t decide(input logic [2:0] op, input logic hit, input logic dirty);
    if (op == OP_UPGR) return '{st: RESP, we: 1'b0, rsp: R_ACK};
    if (dirty) return '{st: op == OP_RD ? MEM_REQ : RESP, we: op == OP_RD, rsp: R_SNOOP};
    return '{st: MEM_REQ, we: 1'b0, rsp: (op == OP_RD && hit) ? R_FETCH : R_FETCH_EXCL};
  endfunction
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CACHE; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_CACHE);
      if (!found && sdt_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end
  // Lowest-index dirty peer supplies data, even if a higher one answered in an earlier cycle.
  always_comb begin
    hit_c   = any_hit;
    dirty_c = dirty_found;
    didx_c  = dirty_idx;
    take    = 1'b0;
    for (int i = NUM_CACHE-1; i >= 0; i--)
      if (state == SNP_COLLECT && pend_sut[i] && sut_valid[i]) begin
        if (rsp_a[i] == 2'd1 || rsp_a[i] == 2'd2) hit_c = 1'b1;
        if (rsp_a[i] == 2'd2 && (!dirty_found || PW'(i) < dirty_idx)) begin
          dirty_c = 1'b1;
          didx_c  = PW'(i);
          take    = 1'b1;
        end
      end
  end
  assign gsel    = NUM_CACHE'(1) << grant;
  assign g_op    = op_a[grant];
  assign is_snp  = g_op == OP_RD || g_op == OP_RDX || g_op == OP_UPGR;
  assign all_sur = (pend_sur & ~sur_ready) == '0;
  assign all_sut = (pend_sut & ~sut_valid) == '0;
  assign d0      = decide(g_op, 1'b0, 1'b0);
  assign dec     = decide(op_q, hit_c, dirty_c);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (found) state_n = !is_snp ? (g_op == OP_WB ? MEM_REQ : RESP) : NUM_CACHE == 1 ? d0.st : SNP_ISSUE;
      SNP_ISSUE:   if (all_sur) state_n = SNP_COLLECT;
      SNP_COLLECT: if (all_sut) state_n = dec.st;
      MEM_REQ:     if (mem_req_ready) state_n = mem_req_we ? RESP : MEM_WAIT;
      MEM_WAIT:    if (mem_rsp_valid) state_n = RESP;
      RESP:        if (sdr_ready[req_idx]) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      req_idx     <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_sur    <= '0;
      pend_sut    <= '0;
      any_hit     <= 1'b0;
      dirty_found <= 1'b0;
      dirty_idx   <= '0;
      mem_req_we  <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (found) begin
          req_idx     <= grant;
          ptr         <= grant == PW'(NUM_CACHE-1) ? '0 : grant + 1'b1;
          op_q        <= g_op;
          addr_q      <= addr_a[grant];
          data_q      <= wdata_a[grant];
          pend_sur    <= ~gsel;
          pend_sut    <= ~gsel;
          any_hit     <= 1'b0;
          dirty_found <= 1'b0;
          dirty_idx   <= '0;
          mem_req_we  <= is_snp ? d0.we : g_op == OP_WB;
          rsp_q       <= is_snp ? d0.rsp : R_ACK;
        end
        SNP_ISSUE: pend_sur <= pend_sur & ~sur_ready;
        SNP_COLLECT: begin
          pend_sut    <= pend_sut & ~sut_valid;
          any_hit     <= hit_c;
          dirty_found <= dirty_c;
          dirty_idx   <= didx_c;
          if (take) data_q <= sdata_a[didx_c];
          if (all_sut) begin
            mem_req_we <= dec.we;
            rsp_q      <= dec.rsp;
          end
        end
        MEM_WAIT: if (mem_rsp_valid) data_q <= mem_rsp_data;
        default: ;
      endcase
    end
  assign sdt_ready     = (state == IDLE && found) ? gsel : '0;
  assign sur_valid     = state == SNP_ISSUE ? pend_sur : '0;
  assign sut_ready     = state == SNP_COLLECT ? pend_sut : '0;
  assign sur_op        = op_q == OP_RD ? 2'd1 : op_q == OP_RDX ? 2'd2 : op_q == OP_UPGR ? 2'd3 : 2'd0;
  assign sur_addr      = addr_q;
  assign mem_req_valid = state == MEM_REQ;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign sdr_valid     = state == RESP ? NUM_CACHE'(1) << req_idx : '0;
  assign sdr_rsp       = state == RESP ? rsp_q : 3'd0;
  assign sdr_data      = data_q;
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed and random bus transactions checked against a transaction-level coherence model
module tb_snoop_bus_ctrl;
  localparam int N = 4, AW = 58, BW = 512;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] sdt_valid, sdt_ready, sdr_valid, sdr_ready, sur_valid, sur_ready, sut_valid, sut_ready;
  logic [3*N-1:0] sdt_op;
  logic [AW*N-1:0] sdt_addr;
  logic [BW*N-1:0] sdt_data, sut_data;
  logic [2:0] sdr_rsp;
  logic [BW-1:0] sdr_data, mem_req_data, mem_rsp_data;
  logic [1:0] sur_op;
  logic [AW-1:0] sur_addr, mem_req_addr;
  logic [2*N-1:0] sut_rsp;
  logic mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [N-1:0] pend;
  logic [2:0] rop [N];
  logic [AW-1:0] raddr [N];
  logic [BW-1:0] rdata [N];
  logic [1:0] prsp [N];
  logic [BW-1:0] pdat [N];
  logic [BW-1:0] mem_fill;
  int m_ptr, dly_sur, dly_sdr, errors = 0, checks = 0;
  snoop_bus_ctrl #(.NUM_CACHE(N), .SADDR_WIDTH(AW), .BLK_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .sdt_valid(sdt_valid), .sdt_ready(sdt_ready), .sdt_op(sdt_op), .sdt_addr(sdt_addr), .sdt_data(sdt_data),
    .sdr_valid(sdr_valid), .sdr_ready(sdr_ready), .sdr_rsp(sdr_rsp), .sdr_data(sdr_data),
    .sur_valid(sur_valid), .sur_ready(sur_ready), .sur_op(sur_op), .sur_addr(sur_addr),
    .sut_valid(sut_valid), .sut_ready(sut_ready), .sut_rsp(sut_rsp), .sut_data(sut_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [BW-1:0] rblk();
    logic [BW-1:0] v;
    for (int w = 0; w < BW/32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction
  task automatic zero_inputs();
    sdt_valid = '0; sdt_op = '0; sdt_addr = '0; sdt_data = '0;
    sdr_ready = '0; sur_ready = '0; sut_valid = '0; sut_rsp = '0; sut_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask
  task automatic clear_model();
    pend = '0;
    for (int i = 0; i < N; i++) begin
      rop[i] = 3'd0; raddr[i] = '0; rdata[i] = '0; prsp[i] = 2'd0; pdat[i] = '0;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask
  task automatic run_bus(input int n_txn, input bit abort);
    int done = 0, cyc = 0, cur = 0, exp_g, fd, rsp_cd = -1, sdr_cnt = 0, hold = 0, n_wr = 0, n_rd = 0;
    int sur_cnt [N];
    bit active = 1'b0, hit;
    logic [N-1:0] e_snp = '0, o_snp = '0;
    logic [2:0] cop, e_rsp = 3'd0;
    logic [1:0] e_sop = 2'd0;
    int e_wr = 0, e_rd = 0;
    logic [BW-1:0] e_data = '0, e_wdata = '0, o_mdata = '0;
    logic [AW-1:0] o_maddr = '0;
    for (int i = 0; i < N; i++) sur_cnt[i] = 0;
    while (done < n_txn && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      sdt_valid = pend;
      for (int i = 0; i < N; i++) begin
        sdt_op[3*i +: 3] = rop[i];
        sdt_addr[AW*i +: AW] = raddr[i];
        sdt_data[BW*i +: BW] = rdata[i];
        sut_rsp[2*i +: 2] = prsp[i];
        sut_data[BW*i +: BW] = pdat[i];
        sur_cnt[i] = sur_valid[i] ? sur_cnt[i] + 1 : 0;
        sur_ready[i] = sur_valid[i] && sur_cnt[i] > dly_sur;
        sut_valid[i] = sut_ready[i] && ($urandom_range(0, 1) == 1);
      end
      mem_req_ready = mem_req_valid && ($urandom_range(0, 2) != 0);
      mem_rsp_valid = rsp_cd == 0;
      mem_rsp_data = mem_fill;
      if (rsp_cd >= 0) rsp_cd--;
      sdr_cnt = sdr_valid != '0 ? sdr_cnt + 1 : 0;
      sdr_ready = sdr_cnt > dly_sdr ? sdr_valid : '0;
      #1;
      if (active) chk("sdt_ready_busy", sdt_ready, '0);
      else if ((sdt_valid & sdt_ready) != '0) begin
        exp_g = -1;
        for (int k = 0; k < N; k++) if (exp_g < 0 && pend[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
        chk("grant", sdt_ready, 1 << exp_g);
        cur = exp_g; pend[cur] = 1'b0; m_ptr = (cur + 1) % N; active = 1'b1;
        o_snp = '0; n_wr = 0; n_rd = 0; hold = 0;
        cop = rop[cur]; e_sop = cop[1:0]; e_snp = '0; e_wr = 0; e_rd = 0; e_rsp = 3'd4;
        e_data = '0; e_wdata = rdata[cur];
        if (cop == 3'd4) e_wr = 1;
        else if (cop >= 3'd1 && cop <= 3'd3) begin
          e_snp = ~(N'(1) << cur);
          fd = -1; hit = 1'b0;
          for (int p = 0; p < N; p++) if (p != cur) begin
            if (prsp[p] == 2'd2 && fd < 0) fd = p;
            if (prsp[p] == 2'd1 || prsp[p] == 2'd2) hit = 1'b1;
          end
          if (cop == 3'd3) e_rsp = 3'd4;
          else if (fd >= 0) begin
            e_rsp = 3'd1; e_data = pdat[fd];
            if (cop == 3'd1) begin e_wr = 1; e_wdata = pdat[fd]; end
          end else begin
            e_rd = 1; e_data = mem_fill;
            e_rsp = (cop == 3'd1 && hit) ? 3'd2 : 3'd3;
          end
        end
      end
      if (active) begin
        if (sur_valid != '0) begin
          chk("sur_op", sur_op, e_sop);
          chk("sur_addr", sur_addr, raddr[cur]);
        end
        o_snp |= sur_valid & sur_ready;
        if (mem_req_valid && mem_req_ready) begin
          if (mem_req_we) n_wr++;
          else begin
            n_rd++;
            if (!abort) rsp_cd = $urandom_range(0, 3);
          end
          o_maddr = mem_req_addr;
          o_mdata = mem_req_data;
        end
        if (abort && n_rd > 0) begin
          hold++;
          if (hold == 3) return;
        end
        if (sdr_valid != '0) chk("sdr_rsp", sdr_rsp, e_rsp);
        if ((sdr_valid & sdr_ready) != '0) begin
          chk("sdr_valid", sdr_valid, 1 << cur);
          if (e_rsp != 3'd4) chk("sdr_data", sdr_data, e_data);
          chk("snoop_set", o_snp, e_snp);
          chk("mem_wr", n_wr, e_wr);
          chk("mem_rd", n_rd, e_rd);
          if (e_wr + e_rd > 0) chk("mem_addr", o_maddr, raddr[cur]);
          if (e_wr > 0) chk("mem_wdata", o_mdata, e_wdata);
          done++;
          active = 1'b0;
        end
      end
    end
    if (abort) chk("abort_point", hold, 3);
    else chk("txn_count", done, n_txn);
    @(negedge clk);
    sur_ready = '0; sut_valid = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; sdr_ready = '0;
    sdt_valid = pend;
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_sdt_ready"}, sdt_ready, '0);
    chk({tag, "_sur_valid"}, sur_valid, '0);
    chk({tag, "_sut_ready"}, sut_ready, '0);
    chk({tag, "_sdr_valid"}, sdr_valid, '0);
    chk({tag, "_sdr_rsp"}, sdr_rsp, '0);
    chk({tag, "_mem_valid"}, mem_req_valid, '0);
  endtask
  initial begin
    int n;
    clear_model();
    dly_sur = 0; dly_sdr = 0; mem_fill = '0;
    do_reset();
    #1 check_idle("reset");
    raddr[0] = 58'h10; rop[0] = 3'd1; mem_fill = {64{8'hAA}}; pend = 4'b0001;
    run_bus(1, 1'b0);
    clear_model();
    raddr[1] = 58'h2040; rop[1] = 3'd1; prsp[2] = 2'd2; pdat[2] = {64{8'h55}}; pend = 4'b0010;
    run_bus(1, 1'b0);
    clear_model();
    raddr[0] = 58'h300; rop[0] = 3'd1; prsp[3] = 2'd1; mem_fill = {64{8'h3C}}; pend = 4'b0001;
    run_bus(1, 1'b0);
    clear_model();
    raddr[2] = 58'h444; rop[2] = 3'd3; prsp[0] = 2'd1; pend = 4'b0100;
    run_bus(1, 1'b0);
    clear_model();
    raddr[3] = 58'h555; rop[3] = 3'd4; rdata[3] = {64{8'h77}}; pend = 4'b1000;
    run_bus(1, 1'b0);
    clear_model();
    do_reset();
    dly_sur = 3; dly_sdr = 3; mem_fill = {64{8'h5A}};
    for (int i = 0; i < N; i++) begin rop[i] = 3'd1; raddr[i] = AW'(58'h1000 + i); end
    pend = 4'b1111;
    run_bus(4, 1'b0);
    pend = 4'b0101;
    run_bus(2, 1'b0);
    dly_sur = 0; dly_sdr = 0;
    clear_model();
    raddr[1] = 58'h777; rop[1] = 3'd1; pend = 4'b0010;
    run_bus(1, 1'b1);
    rst_n = 1'b0;
    zero_inputs();
    @(negedge clk);
    #1 check_idle("abort");
    rst_n = 1'b1;
    m_ptr = 0;
    mem_rsp_valid = 1'b1; mem_rsp_data = {64{8'hEE}};
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_idle("late_rsp");
    mem_fill = {64{8'h99}}; raddr[1] = 58'h778; pend = 4'b0010;
    run_bus(1, 1'b0);
    for (int r = 0; r < 25; r++) begin
      clear_model();
      pend = N'($urandom_range(1, (1 << N) - 1));
      n = 0;
      for (int i = 0; i < N; i++) begin
        rop[i] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) != 0) rop[i] = 3'($urandom_range(1, 2));
        raddr[i] = {$urandom(), $urandom()} >> 6;
        rdata[i] = rblk();
        prsp[i] = 2'($urandom_range(0, 3));
        pdat[i] = rblk();
        if (pend[i]) n++;
      end
      mem_fill = rblk();
      dly_sur = $urandom_range(0, 3);
      dly_sdr = $urandom_range(0, 3);
      run_bus(n, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/snoop_bus_ctrl.md
Name: snoop_bus_ctrl

Overview:
- Shared coherence-bus controller downstream of every cache_mem instance's sdt/sdr ports, and driver of all caches' sur/sut snoop ports.
- Round-robin arbitrates one cache request at a time, broadcasts the matching snoop to all peer caches, collects their responses, and accesses the memory port when needed.
- Returns the fill/ack response to the requester; this single-transaction atomic bus serialises MESI coherence.

Parameters:
NUM_CACHE, 4, number of attached caches (>=1)
SADDR_WIDTH, 58, block address width
BLK_WIDTH, 512, block data width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
sdt_valid  in  NUM_CACHE  per-cache bus request valid
sdt_ready  out  NUM_CACHE  per-cache request accept
sdt_op  in  3*NUM_CACHE  per-cache op: 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPGR, 4 BUS_WB; 0/5-7 reserved
sdt_addr  in  SADDR_WIDTH*NUM_CACHE  per-cache block address
sdt_data  in  BLK_WIDTH*NUM_CACHE  per-cache writeback data
sdr_valid  out  NUM_CACHE  response valid, one-hot to requester
sdr_ready  in  NUM_CACHE  response accept
sdr_rsp  out  3  1 SNOOP (peer data), 2 FETCH (mem data, shared), 3 FETCH_EXCL (mem data, no sharer), 4 ACK, 0 none
sdr_data  out  BLK_WIDTH  fill data
sur_valid  out  NUM_CACHE  snoop valid to peers
sur_ready  in  NUM_CACHE  snoop accept
sur_op  out  2  1 SNP_RD, 2 SNP_RDX, 3 SNP_INV
sur_addr  out  SADDR_WIDTH  snoop address
sut_valid  in  NUM_CACHE  snoop response valid
sut_ready  out  NUM_CACHE  snoop response accept
sut_rsp  in  2*NUM_CACHE  0 MISS, 1 HIT_CLEAN, 2 HIT_DIRTY (data valid); 3 treated as MISS
sut_data  in  BLK_WIDTH*NUM_CACHE  dirty data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accept
mem_req_we  out  1  1 write, 0 read
mem_req_addr  out  SADDR_WIDTH  memory address
mem_req_data  out  BLK_WIDTH  write data
mem_rsp_valid  in  1  read data valid (single-cycle pulse, always accepted)
mem_rsp_data  in  BLK_WIDTH  read data

Behaviour:
- Reset: all valid/ready outputs 0, sdr_rsp 0, state IDLE, RR pointer 0. Data/addr outputs are don't-care but reset to 0.
- Reset mid-transaction aborts immediately to IDLE; no response is issued.
- States: IDLE, SNP_ISSUE, SNP_COLLECT, MEM_REQ, MEM_WAIT, RESP.
- IDLE: grant the first valid requester at or after the RR pointer. Pulse its sdt_ready that cycle (one-cycle accept) and latch op/addr/data. Pointer becomes grant+1 mod NUM_CACHE.
- IDLE next state:
  - BUS_RD/RDX/UPGR -> SNP_ISSUE; skip straight to the post-collect decision if NUM_CACHE==1.
  - BUS_WB -> MEM_REQ as a write.
  - Reserved op -> RESP with ACK.
- SNP_ISSUE: sur_valid is high for every peer (all except the requester). Each bit clears on its sur_ready handshake. sur_op/sur_addr hold stable. Go to SNP_COLLECT when all peers have accepted.
- SNP_COLLECT: sut_ready is high per peer until that peer's sut_valid handshake. Record any_hit and first_dirty (lowest index wins) with its data. More than one dirty is a protocol error: lowest index used, no assertion in RTL. Advance when all peers have responded.
- Decision after collect:
  - RD + dirty: memory write of the dirty data (MEM_REQ we=1), then RESP SNOOP with the peer data.
  - RD + clean hit: memory read -> FETCH.
  - RD + no hit: memory read -> FETCH_EXCL.
  - RDX + dirty: RESP SNOOP with no memory write.
  - RDX otherwise: memory read -> FETCH_EXCL.
  - UPGR: RESP ACK.
- MEM_REQ: mem_req_valid held until mem_req_ready.
  - Write -> RESP.
  - Read -> MEM_WAIT, which latches mem_rsp_data on mem_rsp_valid -> RESP.
  - BUS_WB write -> RESP ACK.
- RESP: requester's sdr_valid, sdr_rsp and sdr_data held until sdr_ready, then IDLE. Only after that return is the next grant possible, so there is at least one IDLE cycle between transactions.
- Requests arriving during a transaction wait; sdt_ready is never asserted outside IDLE.
- mem_rsp_valid outside MEM_WAIT is ignored.

Test Plan:
- Cache0 BUS_RD addr 0x10, peers return MISS, mem returns 0xAA..: mem read addr 0x10; cache0 gets sdr_rsp=3 with data 0xAA...
- Cache1 BUS_RD, cache2 returns HIT_DIRTY data 0x55..: mem write 0x55.. to the address, then cache1 gets sdr_rsp=1 with data 0x55...
- Cache0 BUS_RD, cache3 returns HIT_CLEAN: cache0 gets sdr_rsp=2 with the mem data.
- Cache2 BUS_UPGR: sur_op=3 to caches 0,1,3 only, no mem activity, sdr_rsp=4. Cache3 BUS_WB: no snoop, mem we=1 with its data, sdr_rsp=4.
- All four caches request simultaneously from reset: grants in order 0,1,2,3; then a cache0 re-request plus cache2 with pointer=0 grants 0 before 2. sur_ready and sdr_ready are delayed 3 cycles; outputs stay stable.
- rst_n asserted in MEM_WAIT: next cycle all valids 0, IDLE; a late mem_rsp_valid is ignored; the next request proceeds normally.
